// File: rtl/ula_raster_gen_if.sv
// Bundle of the pixel enable, config port and raster timing outputs of ula_raster_gen.
// slave is the generator side; master is the consumer/host side.
interface ula_raster_gen_if #(
    parameter int HC_W = 9,
    parameter int VC_W = 9
);
    logic            ce_pix;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [15:0]     cfg_din;
    logic [15:0]     cfg_dout;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            border;
    logic            hblank;
    logic            hsync;
    logic            vsync;
    logic            nINT;
    logic            line_irq;
    logic            frame_start;
    logic            flash_phase;

    modport slave (
        input  ce_pix, cfg_we, cfg_addr, cfg_din,
        output cfg_dout, hc, vc, border, hblank, hsync, vsync,
               nINT, line_irq, frame_start, flash_phase
    );

    modport master (
        output ce_pix, cfg_we, cfg_addr, cfg_din,
        input  cfg_dout, hc, vc, border, hblank, hsync, vsync,
               nINT, line_irq, frame_start, flash_phase
    );
endinterface

// File: rtl/ula_raster_gen.sv
// Programmable raster/interrupt timing generator. Timing registers are shadowed
// and copied to the active set at frame wrap; adds a sticky raster-line IRQ.
module ula_raster_gen #(
    parameter int HC_W     = 9,
    parameter int VC_W     = 9,
    parameter int FLASH_W  = 5,
    parameter int H_TOTAL  = 447,
    parameter int V_TOTAL  = 311,
    parameter int INT_LINE = 248,
    parameter int INT_COL  = 4,
    parameter int INT_LEN  = 64
) (
    input  logic          clk_sys,
    input  logic          reset,
    ula_raster_gen_if.slave bus
);
    localparam int          NREG  = 14;
    localparam logic [15:0] HMASK = 16'((1 << HC_W) - 1);
    localparam logic [15:0] VMASK = 16'((1 << VC_W) - 1);

    function automatic logic [15:0] reg_mask(input int idx);
        case (idx)
            1, 6, 7, 8, 13: reg_mask = VMASK;
            10:             reg_mask = 16'h007F;
            11:             reg_mask = 16'h8000 | VMASK;
            default:        reg_mask = HMASK;
        endcase
    endfunction

    function automatic logic [15:0] reg_init(input int idx);
        int v;
        case (idx)
            0:       v = H_TOTAL;
            1:       v = V_TOTAL;
            2:       v = 312;
            3:       v = 416;
            4:       v = 336;
            5:       v = 368;
            6:       v = 240;
            7:       v = 244;
            8:       v = INT_LINE;
            9:       v = INT_COL;
            10:      v = INT_LEN;
            12:      v = 256;
            13:      v = 192;
            default: v = 0;
        endcase
        reg_init = 16'(v) & reg_mask(idx);
    endfunction

    logic [15:0] shadow_q [NREG];
    logic [15:0] active_q [NREG];

    logic [HC_W-1:0]    hc_q, hc_d, hc_nx;
    logic [VC_W-1:0]    vc_q, vc_d, vc_nx;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic [6:0]         int_cnt_q, int_cnt_d;
    logic hblank_q, hblank_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic border_q, border_d, nint_q, nint_d;
    logic line_irq_q, line_irq_d, frame_start_q, frame_start_d;
    logic h_wrap, v_wrap, frame_wrap, lirq_set, lirq_ack;

    logic [HC_W-1:0] h_total, hbl_start, hbl_end, hs_start, hs_end, int_col, act_w;
    logic [VC_W-1:0] v_total, vs_start, vs_end, int_line, lirq_line, act_h;
    logic [6:0]      int_len;
    logic            lirq_en;

    // Shadow takes writes at any time; active follows shadow only on the wrap tick.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
            localparam logic [15:0] RST_V = reg_init(gi);
            localparam logic [15:0] MASK  = reg_mask(gi);
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    shadow_q[gi] <= RST_V;
                    active_q[gi] <= RST_V;
                end else begin
                    if (bus.cfg_we && bus.cfg_addr == 4'(gi))
                        shadow_q[gi] <= bus.cfg_din & MASK;
                    if (bus.ce_pix && frame_wrap)
                        active_q[gi] <= shadow_q[gi];
                end
            end
        end
    endgenerate

    assign h_total   = active_q[0][HC_W-1:0];
    assign v_total   = active_q[1][VC_W-1:0];
    assign hbl_start = active_q[2][HC_W-1:0];
    assign hbl_end   = active_q[3][HC_W-1:0];
    assign hs_start  = active_q[4][HC_W-1:0];
    assign hs_end    = active_q[5][HC_W-1:0];
    assign vs_start  = active_q[6][VC_W-1:0];
    assign vs_end    = active_q[7][VC_W-1:0];
    assign int_line  = active_q[8][VC_W-1:0];
    assign int_col   = active_q[9][HC_W-1:0];
    assign int_len   = active_q[10][6:0];
    assign lirq_line = active_q[11][VC_W-1:0];
    assign lirq_en   = active_q[11][15];
    assign act_w     = active_q[12][HC_W-1:0];
    assign act_h     = active_q[13][VC_W-1:0];

    logic unused_bits;
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < NREG; i++) unused_bits = unused_bits ^ (^active_q[i]);
    end

    assign h_wrap     = hc_q >= h_total;
    assign v_wrap     = vc_q >= v_total;
    assign frame_wrap = h_wrap && v_wrap;
    assign hc_nx      = h_wrap ? '0 : hc_q + 1'b1;
    assign vc_nx      = h_wrap ? (v_wrap ? '0 : vc_q + 1'b1) : vc_q;
    assign lirq_set   = bus.ce_pix && lirq_en && vc_nx == lirq_line && hc_nx == '0;
    assign lirq_ack   = bus.cfg_we && bus.cfg_addr == 4'd14;

    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        flash_d       = flash_q;
        hblank_d      = hblank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        border_d      = border_q;
        nint_d        = nint_q;
        int_cnt_d     = int_cnt_q;
        frame_start_d = frame_start_q;
        line_irq_d    = line_irq_q;
        if (bus.ce_pix) begin
            hc_d          = hc_nx;
            vc_d          = vc_nx;
            frame_start_d = frame_wrap;
            if (frame_wrap) flash_d = flash_q + 1'b1;
            // End match is tested first so start==end keeps the signal low.
            if (hc_nx == hbl_end)        hblank_d = 1'b0;
            else if (hc_nx == hbl_start) hblank_d = 1'b1;
            if (hc_nx == hs_end)         hsync_d  = 1'b0;
            else if (hc_nx == hs_start)  hsync_d  = 1'b1;
            if (vc_nx == vs_end)         vsync_d  = 1'b0;
            else if (vc_nx == vs_start)  vsync_d  = 1'b1;
            border_d = (hc_nx >= act_w) || (vc_nx >= act_h);
            if (!nint_q) begin
                if (int_cnt_q <= 7'd1) begin
                    nint_d    = 1'b1;
                    int_cnt_d = '0;
                end else begin
                    int_cnt_d = int_cnt_q - 1'b1;
                end
            end else if (vc_nx == int_line && hc_nx == int_col && int_len != '0) begin
                nint_d    = 1'b0;
                int_cnt_d = int_len;
            end
        end
        if (lirq_set)      line_irq_d = 1'b1;
        else if (lirq_ack) line_irq_d = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            flash_q       <= '0;
            hblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            border_q      <= 1'b0;
            nint_q        <= 1'b1;
            int_cnt_q     <= '0;
            frame_start_q <= 1'b0;
            line_irq_q    <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            flash_q       <= flash_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            border_q      <= border_d;
            nint_q        <= nint_d;
            int_cnt_q     <= int_cnt_d;
            frame_start_q <= frame_start_d;
            line_irq_q    <= line_irq_d;
        end
    end

    always_comb begin
        bus.cfg_dout = '0;
        if (bus.cfg_addr < 4'd14)       bus.cfg_dout = shadow_q[bus.cfg_addr];
        else if (bus.cfg_addr == 4'd14) bus.cfg_dout = {15'b0, line_irq_q};
    end

    assign bus.hc          = hc_q;
    assign bus.vc          = vc_q;
    assign bus.border      = border_q;
    assign bus.hblank      = hblank_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.nINT        = nint_q;
    assign bus.line_irq    = line_irq_q;
    assign bus.frame_start = frame_start_q;
    assign bus.flash_phase = flash_q[FLASH_W-1];
endmodule
